uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the team's UART_TX. It deserialises frames of start bit, 8 data bits LSB first, optional parity, and one stop bit from the serial line. Receive clock runs at Prescale × baud and each bit is resolved by majority vote over mid-bit oversamples. It delivers parallel bytes with a one-cycle valid strobe and flags parity and stop-bit errors to the system side.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_sampler.sv | 60 ++++++
 rtl/uart_rx.sv | 114 +++++++++++
 tb/tb_uart_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, parity encoding, receiver FSM states.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int PRESCALE_8      = 8;
  localparam int PRESCALE_16     = 16;
  localparam int PRESCALE_32     = 32;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } par_typ_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef struct packed {
    logic     par_en;
    par_typ_e par_typ;
  } rx_cfg_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit edge counter and 3-sample mid-bit majority vote.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  cnt_en,
  input  logic                  cnt_clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  rx_s,
  output logic                  sampled_bit,
  output logic                  bit_done,
  output logic                  sample_rdy
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic                  rx_meta;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] half;
  logic [2:0]            smp;

  assign half        = prescale >> 1;
  assign bit_done    = (edge_cnt == prescale - ONE);
  assign sample_rdy  = (edge_cnt == half + TWO);
  assign sampled_bit = maj3(smp);

  // Sync flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Wrapping on bit_done bounds every bit to at most 2^PRESCALE_W clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              edge_cnt <= '0;
    else if (cnt_clr || !cnt_en || bit_done) edge_cnt <= '0;
    else                                    edge_cnt <= edge_cnt + ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp <= 3'b111;
    end else begin
      if (edge_cnt == half - ONE) smp[0] <= rx_s;
      if (edge_cnt == half)       smp[1] <= rx_s;
      if (edge_cnt == half + ONE) smp[2] <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing, error pulses, parallel byte output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int              BCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(DATA_WIDTH - 1);

  rx_state_e             state, next_state;
  logic                  rx_s, sampled_bit, bit_done, sample_rdy;
  logic                  armed, start_det, cnt_en, cnt_clr;
  logic [PRESCALE_W-1:0] prescale_q;
  rx_cfg_t               cfg_q;
  logic [DATA_WIDTH-1:0] shift, p_data_q;
  logic [BCW-1:0]        bit_cnt;
  logic                  par_bad;

  // The detect cycle itself is edge 0 of the start bit.
  assign start_det = (state == IDLE) && !rx_s && armed;
  assign cnt_en    = start_det || (state != IDLE);
  assign cnt_clr   = (state != IDLE) && (next_state == IDLE);

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (RX_IN),
    .cnt_en      (cnt_en),
    .cnt_clr     (cnt_clr),
    .prescale    (prescale_q),
    .rx_s        (rx_s),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done),
    .sample_rdy  (sample_rdy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    Data_Valid = 1'b0;
    PAR_ERR    = 1'b0;
    STP_ERR    = 1'b0;
    case (state)
      IDLE:   if (start_det) next_state = START;
      START: begin
        if (sample_rdy && sampled_bit) next_state = IDLE;
        else if (bit_done)             next_state = DATA;
      end
      DATA:   if (bit_done && bit_cnt == BIT_LAST) next_state = cfg_q.par_en ? PARITY : STOP;
      PARITY: if (bit_done) next_state = STOP;
      STOP: begin
        // Leave mid stop bit so a zero-gap start edge is still caught.
        if (sample_rdy) begin
          next_state = IDLE;
          Data_Valid = sampled_bit && !par_bad;
          STP_ERR    = !sampled_bit;
          PAR_ERR    = par_bad;
        end else if (bit_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign P_DATA = Data_Valid ? shift : p_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      prescale_q <= PRESCALE_W'(PRESCALE_8);
      cfg_q      <= '{par_en: 1'b0, par_typ: EVEN};
      shift      <= '0;
      bit_cnt    <= '0;
      par_bad    <= 1'b0;
      p_data_q   <= '0;
    end else begin
      // A stop error disarms until the line is seen high, so a break yields one error.
      if (STP_ERR)   armed <= 1'b0;
      else if (rx_s) armed <= 1'b1;
      if (start_det) begin
        prescale_q <= Prescale;
        cfg_q      <= '{par_en: PAR_EN, par_typ: par_typ_e'(PAR_TYP)};
        bit_cnt    <= '0;
        par_bad    <= 1'b0;
      end
      if (state == DATA) begin
        if (sample_rdy) shift   <= {sampled_bit, shift[DATA_WIDTH-1:1]};
        if (bit_done)   bit_cnt <= bit_cnt + BCW'(1);
      end
      if (state == PARITY && sample_rdy)
        par_bad <= sampled_bit ^ (^shift) ^ cfg_q.par_typ;
      if (Data_Valid) p_data_q <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences, random frames vs a frame model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       Data_Valid, PAR_ERR, STP_ERR;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         dv, pe, se;
    logic [7:0] pd;
  } ev_t;

  typedef struct {
    int         p;
    bit         pen, ptyp;
    logic [7:0] data;
    bit         par_bit, stop;
    int         low_after;
    bit         dv, pe, se;
    logic [7:0] pd;
  } vec_t;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_good;
  ev_t        exp_q[$];
  ev_t        act_q[$];
  vec_t       tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t ev;
    if (!reset && (Data_Valid || PAR_ERR || STP_ERR)) begin
      ev.cyc = cyc; ev.dv = Data_Valid; ev.pe = PAR_ERR; ev.se = STP_ERR; ev.pd = P_DATA;
      act_q.push_back(ev);
    end
  end

  // Pulse cycle: 2 sync clocks + (start + 8 data + parity) bit-times + half the stop bit + 2.
  function automatic int lat(input int p, input bit pen);
    return 2 + (9 + int'(pen)) * p + p / 2 + 2;
  endfunction

  function automatic ev_t model(input int s, input int p, input bit pen, input bit ptyp,
                                input logic [7:0] d, input bit par_bit, input bit stop);
    ev_t e;
    bit  bad;
    bad   = pen && (par_bit != ((^d) ^ ptyp));
    e.cyc = s + lat(p, pen);
    e.dv  = stop && !bad;
    e.pe  = bad;
    e.se  = !stop;
    e.pd  = e.dv ? d : last_good;
    return e;
  endfunction

  task automatic drive_bit(input bit b, input int n);
    RX_IN = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                            input bit par_bit, input bit stop, input int low_after,
                            input int gap, output int s);
    s        = cyc;
    Prescale = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    drive_bit(1'b0, p);
    // Configuration must have been latched at start detection; disturb it mid-frame.
    Prescale = 6'(8 << $urandom_range(0, 2));
    PAR_EN   = 1'($urandom_range(0, 1));
    PAR_TYP  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(par_bit, p);
    drive_bit(stop, p);
    if (low_after > 0) drive_bit(1'b0, low_after * p);
    if (gap > 0) drive_bit(1'b1, gap);
  endtask

  task automatic check_events(input string tag);
    ev_t e, a;
    drive_bit(1'b1, 16);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s event_count: got %0d required %0d", tag, act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++;
      if (a.cyc != e.cyc) begin
        failures++;
        $display("FAIL %s event_cycle: got %0d required %0d", tag, a.cyc, e.cyc);
      end
      checks++;
      if (a.dv != e.dv || a.pe != e.pe || a.se != e.se || a.pd !== e.pd) begin
        failures++;
        $display("FAIL %s event_fields: got dv=%0b pe=%0b se=%0b data=%02h required dv=%0b pe=%0b se=%0b data=%02h",
                 tag, a.dv, a.pe, a.se, a.pd, e.dv, e.pe, e.se, e.pd);
      end
    end
    exp_q.delete();
    act_q.delete();
    checks++;
    if (P_DATA !== last_good) begin
      failures++;
      $display("FAIL %s p_data_hold: got %02h required %02h", tag, P_DATA, last_good);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({Data_Valid, PAR_ERR, STP_ERR} !== 3'b000) begin
      failures++;
      $display("FAIL %s pulses: got %03b required 000", tag, {Data_Valid, PAR_ERR, STP_ERR});
    end
    checks++;
    if (P_DATA !== 8'h00) begin
      failures++;
      $display("FAIL %s p_data: got %02h required 00", tag, P_DATA);
    end
  endtask

  initial begin
    int   s;
    ev_t  e;
    vec_t v;
    int   p, low, gap;
    bit   pen, ptyp, flip, stop, pb;
    logic [7:0] d;

    reset = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    reset = 1'b0;
    drive_bit(1'b1, 8);

    // p, pen, ptyp, data, parity bit sent, stop bit, low bit-times after stop | dv, pe, se, P_DATA
    tbl.push_back('{8,  1'b0, 1'b0, 8'hD3, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hD3});
    tbl.push_back('{16, 1'b1, 1'b0, 8'hD2, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hD2});
    tbl.push_back('{16, 1'b1, 1'b0, 8'hD2, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'hD2});
    tbl.push_back('{32, 1'b1, 1'b1, 8'hFB, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hFB});
    tbl.push_back('{32, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 8'hFB});
    tbl.push_back('{8,  1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b1, 8'hFB});
    tbl.push_back('{8,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{16, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h7E});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      send_frame(v.p, v.pen, v.ptyp, v.data, v.par_bit, v.stop, v.low_after, 2 * v.p, s);
      e.cyc = s + lat(v.p, v.pen); e.dv = v.dv; e.pe = v.pe; e.se = v.se; e.pd = v.pd;
      exp_q.push_back(e);
      last_good = v.pd;
      check_events($sformatf("vec%0d", i));
    end

    // Three-clock low glitch is rejected, then a real frame still lands.
    Prescale = 6'd8; PAR_EN = 1'b0;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 24);
    check_events("glitch");
    send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 16, s);
    e = model(s, 8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    exp_q.push_back(e); last_good = e.pd;
    check_events("after_glitch");

    // Zero-gap frames: pulses must be exactly 160 clocks apart.
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'h01 : (i == 1) ? 8'h80 : 8'hFF;
      send_frame(16, 1'b0, 1'b0, d, 1'b0, 1'b1, 0, 0, s);
      e = model(s, 16, 1'b0, 1'b0, d, 1'b0, 1'b1);
      exp_q.push_back(e); last_good = e.pd;
    end
    check_events("back_to_back");

    // Reset in the middle of the data bits of 0x3C.
    Prescale = 6'd8; PAR_EN = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    #3 reset = 1'b1;
    #1 check_outputs_zero("reset_mid_frame");
    RX_IN = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    last_good = 8'h00;
    check_events("reset_abort");
    send_frame(8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 0, 16, s);
    e = model(s, 8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1);
    exp_q.push_back(e); last_good = e.pd;
    check_events("after_reset");

    // Random frames scored against the frame model.
    for (int i = 0; i < 40; i++) begin
      p    = 8 << $urandom_range(0, 2);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      d    = 8'($urandom_range(0, 255));
      flip = ($urandom_range(0, 4) == 0);
      stop = ($urandom_range(0, 4) != 0);
      pb   = (^d) ^ ptyp ^ flip;
      low  = stop ? 0 : int'($urandom_range(0, 2));
      gap  = stop ? int'($urandom_range(0, 2 * p)) : p + int'($urandom_range(0, p));
      send_frame(p, pen, ptyp, d, pb, stop, low, gap, s);
      e = model(s, p, pen, ptyp, d, pb, stop);
      exp_q.push_back(e); last_good = e.pd;
    end
    check_events("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
